tim_capture_channel: RTL and testbench
======================================

TIM_CAPTURE_CHANNEL -- requirements
Module: tim_capture_channel

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the counter input and capture register.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchroniser flops (legal range 2..4).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic in this one domain.
REQ-004 SHALL have port aresetn_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cnt_i, input, CNT_WIDTH, the timer counter value to capture.
REQ-006 SHALL have port ti_i, input, 1, asynchronous external timer input pin.
REQ-007 SHALL have port ti_alt_i, input, 1, filtered input of the paired channel (synchronous level).
REQ-008 SHALL have port trc_i, input, 1, trigger-controller signal (synchronous level).
REQ-009 SHALL have ports ccs_i (2, source select), ckd_i (2, filter clock divide), icf_i (4, filter length), icps_i (2, prescaler), all inputs.
REQ-010 SHALL have ports cce_i, ccp_i, ccnp_i, ccif_clr_i, ccof_clr_i, all inputs, 1: capture enable, polarity bits, flag-clear pulses.
REQ-011 SHALL have outputs tif_o (1, filtered level), ccr_o (CNT_WIDTH, capture register), cap_pulse_o (1), ccif_o (1, capture flag), ccof_o (1, overcapture flag).

Function
REQ-012 SHALL synchronise ti_i through SYNC_STAGES flops before any other use.
REQ-013 SHALL generate a sample tick every 1, 2, 4, 4 clk_i cycles for ckd_i = 0, 1, 2, 3 using a free-running divider counter.
REQ-014 SHALL, when icf_i = 0, register the synchronised input into tif_o every clk_i cycle, ignoring ticks.
REQ-015 SHALL, when icf_i = N > 0, toggle tif_o only after N consecutive ticks where the synchronised sample differs from tif_o; a matching sample clears the run counter.
REQ-016 SHALL select the event source by ccs_i: 00 tif_o, 01 ti_alt_i, 10 trc_i, 11 none (no events).
REQ-017 SHALL detect edges on the selected source against a registered previous value; {ccp_i,ccnp_i}: 00 rising, 10 falling, 11 both, 01 rising.
REQ-018 SHALL reset the previous-value register to the current source value when ccs_i changes, so a source switch produces no event.
REQ-019 SHALL prescale events: icps_i 00 every event, 01 every 2nd, 10 every 4th, 11 every 8th, via a 3-bit counter that captures at count = div-1 and wraps to 0.
REQ-020 SHALL clear the prescaler counter while cce_i = 0 and in the cycle icps_i changes value.
REQ-021 SHALL, on a prescaled event with cce_i = 1, load ccr_o with cnt_i of that cycle and pulse cap_pulse_o high for exactly one cycle on the next cycle.
REQ-022 SHALL yield, with icf_i = 0, ckd_i = 0, ccs_i = 00, icps_i = 00: ti_i rising at cycle 0 -> ccr_o = cnt_i of cycle SYNC_STAGES+1, cap_pulse_o high in cycle SYNC_STAGES+2.
REQ-023 SHALL set ccif_o on every capture; ccif_clr_i clears it; simultaneous capture and clear leaves ccif_o = 1.
REQ-024 SHALL set ccof_o when a capture occurs while ccif_o = 1; ccof_clr_i clears it; set wins over clear; ccr_o is still overwritten.
REQ-025 SHALL, with cce_i = 0, keep synchroniser, filter and edge register running, suppress captures, and hold ccr_o, ccif_o, ccof_o.
REQ-026 SHALL keep all counters saturating or wrapping within their declared widths; no undefined state.

Reset
REQ-027 SHALL, on aresetn_i low, asynchronously clear synchroniser, filter state, tif_o, edge register, all counters, ccr_o, cap_pulse_o, ccif_o, ccof_o to 0.
REQ-028 SHALL resume from reset state on the first clk_i edge after release; an in-progress filter run or prescale count is discarded.

Verification
REQ-029 SHALL verify basic capture: default settings, cnt_i increments per cycle from 0x0000, ti_i rises at cycle 10 -> cap_pulse_o at cycle 14, ccr_o = 0x000D, ccif_o = 1.
REQ-030 SHALL verify filter: icf_i = 4, ckd_i = 1, 3-tick glitch -> tif_o unchanged; 4-tick-stable high -> tif_o = 1 after 8 clk_i following the synchronised change.
REQ-031 SHALL verify prescaler: icps_i = 10, eight rising edges -> exactly two captures, on edges 4 and 8.
REQ-032 SHALL verify overcapture: two captures without clear -> ccof_o = 1, ccr_o = second value; capture coincident with ccif_clr_i -> ccif_o stays 1.
REQ-033 SHALL verify polarity/source: {ccp_i,ccnp_i} = 11 with ti_i pulse -> two captures; switching ccs_i while sources differ -> no capture.
REQ-034 SHALL verify reset mid-operation: aresetn_i low during a filter run with ccif_o = 1 -> all outputs 0 immediately, no capture after release without a new edge.

Source files
------------

// File: rtl/tim_capture_channel.sv
// Timer input-capture channel: synchroniser, digital filter, edge/source select,
// event prescaler and capture register with capture/overcapture flags.
module tim_capture_channel #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 ti_i,
  input  logic                 ti_alt_i,
  input  logic                 trc_i,
  input  logic [1:0]           ccs_i,
  input  logic [1:0]           ckd_i,
  input  logic [3:0]           icf_i,
  input  logic [1:0]           icps_i,
  input  logic                 cce_i,
  input  logic                 ccp_i,
  input  logic                 ccnp_i,
  input  logic                 ccif_clr_i,
  input  logic                 ccof_clr_i,
  output logic                 tif_o,
  output logic [CNT_WIDTH-1:0] ccr_o,
  output logic                 cap_pulse_o,
  output logic                 ccif_o,
  output logic                 ccof_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             divCnt_q, divCnt_d;
  logic [3:0]             runCnt_q, runCnt_d;
  logic                   tif_q, tif_d;
  logic                   srcPrev_q, srcPrev_d;
  logic [1:0]             ccsPrev_q, ccsPrev_d;
  logic [1:0]             icpsPrev_q, icpsPrev_d;
  logic [2:0]             pscCnt_q, pscCnt_d;
  logic [CNT_WIDTH-1:0]   ccr_q, ccr_d;
  logic                   capPulse_q, capPulse_d;
  logic                   ccif_q, ccif_d;
  logic                   ccof_q, ccof_d;

  logic       synced;
  logic       sampleTick;
  logic       src;
  logic       riseHit;
  logic       fallHit;
  logic       edgeHit;
  logic       eventHit;
  logic [2:0] pscLast;
  logic [2:0] pscBase;
  logic       capture;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], ti_i};
    divCnt_d = divCnt_q + 2'd1;

    sampleTick = 1'b0;
    case (ckd_i)
      2'd0:    sampleTick = 1'b1;
      2'd1:    sampleTick = divCnt_q[0];
      default: sampleTick = (divCnt_q == 2'b11);
    endcase

    // Filter toggles only after icf_i consecutive disagreeing ticks; >= guards against icf_i shrinking mid-run.
    tif_d    = tif_q;
    runCnt_d = runCnt_q;
    if (icf_i == 4'd0) begin
      tif_d    = synced;
      runCnt_d = 4'd0;
    end else if (sampleTick) begin
      if (synced != tif_q) begin
        if (({1'b0, runCnt_q} + 5'd1) >= {1'b0, icf_i}) begin
          tif_d    = ~tif_q;
          runCnt_d = 4'd0;
        end else begin
          runCnt_d = runCnt_q + 4'd1;
        end
      end else begin
        runCnt_d = 4'd0;
      end
    end

    src = 1'b0;
    case (ccs_i)
      2'b00:   src = tif_q;
      2'b01:   src = ti_alt_i;
      2'b10:   src = trc_i;
      default: src = 1'b0;
    endcase

    riseHit = src & ~srcPrev_q;
    fallHit = ~src & srcPrev_q;
    if (ccp_i && ccnp_i) begin
      edgeHit = riseHit | fallHit;
    end else if (ccp_i) begin
      edgeHit = fallHit;
    end else begin
      edgeHit = riseHit;
    end

    // A source switch re-seeds the previous value, so the switch itself never fires.
    eventHit  = edgeHit && (ccs_i == ccsPrev_q) && (ccs_i != 2'b11);
    srcPrev_d = src;
    ccsPrev_d = ccs_i;

    pscLast = 3'd0;
    case (icps_i)
      2'b00:   pscLast = 3'd0;
      2'b01:   pscLast = 3'd1;
      2'b10:   pscLast = 3'd3;
      default: pscLast = 3'd7;
    endcase

    icpsPrev_d = icps_i;
    pscBase    = (!cce_i || (icps_i != icpsPrev_q)) ? 3'd0 : pscCnt_q;
    capture    = eventHit && cce_i && (pscBase == pscLast);
    pscCnt_d   = pscBase;
    if (cce_i && eventHit) begin
      pscCnt_d = capture ? 3'd0 : pscBase + 3'd1;
    end

    ccr_d      = capture ? cnt_i : ccr_q;
    capPulse_d = capture;

    ccif_d = ccif_q;
    if (capture) begin
      ccif_d = 1'b1;
    end else if (ccif_clr_i) begin
      ccif_d = 1'b0;
    end

    ccof_d = ccof_q;
    if (capture && ccif_q) begin
      ccof_d = 1'b1;
    end else if (ccof_clr_i) begin
      ccof_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      sync_q     <= '0;
      divCnt_q   <= 2'd0;
      runCnt_q   <= 4'd0;
      tif_q      <= 1'b0;
      srcPrev_q  <= 1'b0;
      ccsPrev_q  <= 2'b00;
      icpsPrev_q <= 2'b00;
      pscCnt_q   <= 3'd0;
      ccr_q      <= '0;
      capPulse_q <= 1'b0;
      ccif_q     <= 1'b0;
      ccof_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      divCnt_q   <= divCnt_d;
      runCnt_q   <= runCnt_d;
      tif_q      <= tif_d;
      srcPrev_q  <= srcPrev_d;
      ccsPrev_q  <= ccsPrev_d;
      icpsPrev_q <= icpsPrev_d;
      pscCnt_q   <= pscCnt_d;
      ccr_q      <= ccr_d;
      capPulse_q <= capPulse_d;
      ccif_q     <= ccif_d;
      ccof_q     <= ccof_d;
    end
  end

  assign tif_o       = tif_q;
  assign ccr_o       = ccr_q;
  assign cap_pulse_o = capPulse_q;
  assign ccif_o      = ccif_q;
  assign ccof_o      = ccof_q;

endmodule

// File: tb/tb_tim_capture_channel.sv
// Directed bench for tim_capture_channel; expected capture values are queued
// when an edge is driven and compared against ccr_o whenever cap_pulse_o fires.
module tb_tim_capture_channel;

  logic        clk_i;
  logic        aresetn_i;
  logic [15:0] cnt_i;
  logic        ti_i;
  logic        ti_alt_i;
  logic        trc_i;
  logic [1:0]  ccs_i;
  logic [1:0]  ckd_i;
  logic [3:0]  icf_i;
  logic [1:0]  icps_i;
  logic        cce_i;
  logic        ccp_i;
  logic        ccnp_i;
  logic        ccif_clr_i;
  logic        ccof_clr_i;
  logic        tif_o;
  logic [15:0] ccr_o;
  logic        cap_pulse_o;
  logic        ccif_o;
  logic        ccof_o;

  int          compared   = 0;
  int          mismatched = 0;
  int          capCount   = 0;
  logic [15:0] expQ[$];

  tim_capture_channel #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .aresetn_i   (aresetn_i),
    .cnt_i       (cnt_i),
    .ti_i        (ti_i),
    .ti_alt_i    (ti_alt_i),
    .trc_i       (trc_i),
    .ccs_i       (ccs_i),
    .ckd_i       (ckd_i),
    .icf_i       (icf_i),
    .icps_i      (icps_i),
    .cce_i       (cce_i),
    .ccp_i       (ccp_i),
    .ccnp_i      (ccnp_i),
    .ccif_clr_i  (ccif_clr_i),
    .ccof_clr_i  (ccof_clr_i),
    .tif_o       (tif_o),
    .ccr_o       (ccr_o),
    .cap_pulse_o (cap_pulse_o),
    .ccif_o      (ccif_o),
    .ccof_o      (ccof_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance n cycles; cnt_i follows the cycle number like a free-running timer.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      cnt_i = cnt_i + 16'd1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every capture pulse must match the oldest outstanding expected capture.
  always @(negedge clk_i) begin
    if (cap_pulse_o === 1'b1) begin
      capCount++;
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $error("[TB] FAIL unexpected_capture: observed ccr_o=%0h expected no capture", ccr_o);
      end else begin
        logic [15:0] exp;
        exp = expQ.pop_front();
        assert (ccr_o === exp) else begin
          mismatched++;
          $error("[TB] FAIL capture_value: observed=%0h expected=%0h", ccr_o, exp);
        end
      end
    end
  end

  initial begin
    logic [15:0] capA;
    logic [15:0] capB;
    logic [15:0] cap8;
    int          capStart;

    aresetn_i  = 1'b1;
    cnt_i      = 16'd0;
    ti_i       = 1'b0;
    ti_alt_i   = 1'b0;
    trc_i      = 1'b0;
    ccs_i      = 2'b00;
    ckd_i      = 2'b00;
    icf_i      = 4'd0;
    icps_i     = 2'b00;
    cce_i      = 1'b1;
    ccp_i      = 1'b0;
    ccnp_i     = 1'b0;
    ccif_clr_i = 1'b0;
    ccof_clr_i = 1'b0;
    #1 aresetn_i = 1'b0;
    applyStimulus(2);
    checkOutput("reset_tif", tif_o, 0);
    checkOutput("reset_ccr", ccr_o, 0);
    checkOutput("reset_cap_pulse", cap_pulse_o, 0);
    checkOutput("reset_ccif", ccif_o, 0);
    checkOutput("reset_ccof", ccof_o, 0);

    // Basic capture: ti_i rises in cycle 10, capture of cycle 13, pulse in cycle 14.
    applyStimulus(1);
    aresetn_i = 1'b1;
    cnt_i     = 16'd0;
    applyStimulus(10);
    ti_i = 1'b1;
    expQ.push_back(16'h000D);
    applyStimulus(3);
    checkOutput("basic_pulse_early", cap_pulse_o, 0);
    applyStimulus(1);
    checkOutput("basic_pulse", cap_pulse_o, 1);
    checkOutput("basic_ccr", ccr_o, 32'h000D);
    checkOutput("basic_ccif", ccif_o, 1);
    checkOutput("basic_ccof", ccof_o, 0);
    applyStimulus(1);
    checkOutput("basic_pulse_one_cycle", cap_pulse_o, 0);

    ccif_clr_i = 1'b1;
    applyStimulus(1);
    ccif_clr_i = 1'b0;
    checkOutput("ccif_clear", ccif_o, 0);

    // Both-edge polarity; each source switch while sources differ must stay silent.
    ccp_i    = 1'b1;
    ccnp_i   = 1'b1;
    ccs_i    = 2'b01;
    ti_alt_i = 1'b0;
    applyStimulus(1);
    checkOutput("switch1_pulse", cap_pulse_o, 0);
    applyStimulus(1);
    checkOutput("switch1_ccif", ccif_o, 0);
    ccs_i = 2'b00;
    applyStimulus(2);
    checkOutput("switch2_ccif", ccif_o, 0);
    ccs_i = 2'b01;
    applyStimulus(2);
    checkOutput("switch3_ccif", ccif_o, 0);

    ti_alt_i = 1'b1;
    capA     = cnt_i;
    expQ.push_back(capA);
    applyStimulus(1);
    ti_alt_i = 1'b0;
    capB     = cnt_i;
    expQ.push_back(capB);
    applyStimulus(1);
    checkOutput("overcap_ccof", ccof_o, 1);
    checkOutput("overcap_ccr_second", ccr_o, {16'd0, capB});
    checkOutput("overcap_ccif", ccif_o, 1);

    ti_alt_i   = 1'b1;
    ccif_clr_i = 1'b1;
    expQ.push_back(cnt_i);
    applyStimulus(1);
    ccif_clr_i = 1'b0;
    checkOutput("clr_vs_capture_ccif", ccif_o, 1);
    ccof_clr_i = 1'b1;
    applyStimulus(1);
    ccof_clr_i = 1'b0;
    checkOutput("ccof_clear", ccof_o, 0);
    checkOutput("ccif_kept", ccif_o, 1);
    ccif_clr_i = 1'b1;
    applyStimulus(1);
    ccif_clr_i = 1'b0;
    checkOutput("ccif_clear2", ccif_o, 0);

    // Prescaler every 4th rising edge: captures on edges 4 and 8 only.
    ccp_i    = 1'b0;
    ccnp_i   = 1'b0;
    icps_i   = 2'b10;
    ti_alt_i = 1'b0;
    applyStimulus(2);
    capStart = capCount;
    cap8     = 16'd0;
    for (int k = 1; k <= 8; k++) begin
      ti_alt_i = 1'b1;
      if (k % 4 == 0) begin
        expQ.push_back(cnt_i);
        cap8 = cnt_i;
      end
      applyStimulus(1);
      ti_alt_i = 1'b0;
      applyStimulus(1);
    end
    applyStimulus(2);
    checkOutput("prescale_count", capCount - capStart, 2);
    checkOutput("prescale_ccof", ccof_o, 1);

    // Filter with captures disabled: glitch rejected, stable level accepted.
    cce_i  = 1'b0;
    icps_i = 2'b00;
    ccs_i  = 2'b00;
    ti_i   = 1'b0;
    applyStimulus(6);
    checkOutput("filter_pre_low", tif_o, 0);
    icf_i = 4'd4;
    ckd_i = 2'b01;
    applyStimulus(2);
    ti_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      checkOutput("glitch_tif_high_phase", tif_o, 0);
    end
    ti_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1);
      checkOutput("glitch_tif_low_phase", tif_o, 0);
    end
    ti_i = 1'b1;
    applyStimulus(8);
    checkOutput("filter_not_yet", tif_o, 0);
    applyStimulus(2);
    checkOutput("filter_accept", tif_o, 1);
    checkOutput("cce0_hold_ccr", ccr_o, {16'd0, cap8});
    checkOutput("cce0_hold_ccif", ccif_o, 1);
    checkOutput("cce0_hold_ccof", ccof_o, 1);

    // Reset during a filter run discards it and clears every output at once.
    ti_i = 1'b0;
    applyStimulus(4);
    #2 aresetn_i = 1'b0;
    #1;
    checkOutput("midreset_tif", tif_o, 0);
    checkOutput("midreset_ccr", ccr_o, 0);
    checkOutput("midreset_cap_pulse", cap_pulse_o, 0);
    checkOutput("midreset_ccif", ccif_o, 0);
    checkOutput("midreset_ccof", ccof_o, 0);
    applyStimulus(2);
    aresetn_i = 1'b1;
    cce_i     = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1);
      checkOutput("post_reset_no_pulse", cap_pulse_o, 0);
    end
    checkOutput("post_reset_tif", tif_o, 0);
    checkOutput("post_reset_ccif", ccif_o, 0);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
